// File: rtl/sb_trans_pkg.sv
// sb_trans_pkg: request types, frame symbols, FSM states and trans_state codes
// shared by the sideband transaction generator and its CRC unit.
package sb_trans_pkg;
  typedef enum logic [2:0] {
    RT_LT_LSE    = 3'd1,
    RT_AT_RD_CMD = 3'd2,
    RT_AT_RD_RSP = 3'd3,
    RT_AT_WR_CMD = 3'd4,
    RT_AT_WR_RSP = 3'd5
  } req_type_e;
  typedef enum logic [3:0] {
    S_DISCONNECT, S_IDLE, S_DLE1, S_STX, S_LSE, S_CLSE, S_ADDR,
    S_LEN, S_DATA, S_CRC_H, S_CRC_L, S_STUFF, S_DLE2, S_ETX
  } state_e;
  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;
  localparam logic [7:0] LSE     = 8'h80;
  localparam logic [7:0] CLSE    = 8'h7F;
  localparam logic [9:0] IDLE_SYM = 10'h3FF;
  localparam logic [9:0] DISC_SYM = 10'h000;
  localparam logic [1:0] TS_DISC = 2'd0;
  localparam logic [1:0] TS_IDLE = 2'd1;
  localparam logic [1:0] TS_TX   = 2'd2;
  function automatic logic [9:0] sym(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction
  // CRC-16 poly 0x8005, MSB-first, one byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/sb_crc16.sv
// sb_crc16: byte-wide CRC-16 accumulator; clear loads the 0xFFFF seed.
module sb_crc16
  import sb_trans_pkg::*;
(
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  logic [15:0] crc_q;
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) crc_q <= '0;
    else if (clr_i) crc_q <= 16'hFFFF;
    else if (en_i) crc_q <= crc16_byte(crc_q, data_i);
  assign crc_o = crc_q;
endmodule

// File: rtl/sb_trans_gen_par.sv
// sb_trans_gen_par: sideband frame generator; serialises LT/AT requests into
// held 10-bit symbols with DLE stuffing and CRC-16 protection.
module sb_trans_gen_par
  import sb_trans_pkg::*;
#(
  parameter int MAX_LEN    = 8,
  parameter int SYM_CYCLES = 10
) (
  input  logic                 sb_clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_type,
  input  logic [7:0]           req_addr,
  input  logic [6:0]           req_len,
  input  logic [8*MAX_LEN-1:0] req_data,
  input  logic                 disconnect_sbtx,
  input  logic                 tdisconnect_tx_min,
  output logic [9:0]           trans,
  output logic [1:0]           trans_state,
  output logic                 trans_sent,
  output logic                 req_err,
  output logic                 disconnected_s
);
  localparam int CW = $clog2(SYM_CYCLES);
  state_e state_q, state_d, ret_q, ret_d, seq;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] idx_q, idx_d;
  logic [2:0] type_q;
  logic [7:0] addr_q;
  logic [6:0] len_q;
  logic [8*MAX_LEN-1:0] data_q;
  logic [9:0] trans_q, trans_d;
  logic [1:0] ts_q, ts_d;
  logic [15:0] crc;
  logic [7:0] byte_d, data_byte;
  logic in_frame, tc, type_ok, len_ok, accept, stuff, crc_en, has_data, wr;
  assign in_frame   = state_q != S_DISCONNECT && state_q != S_IDLE;
  assign tc         = cnt_q == CW'(SYM_CYCLES - 1);
  assign has_data   = type_q == RT_AT_RD_RSP || type_q == RT_AT_WR_CMD;
  assign wr         = type_q == RT_AT_WR_CMD || type_q == RT_AT_WR_RSP;
  assign type_ok    = req_type >= 3'd1 && req_type <= 3'd5;
  assign len_ok     = !(req_type == RT_AT_RD_RSP || req_type == RT_AT_WR_CMD) ||
                      (req_len != 7'd0 && req_len <= 7'(MAX_LEN));
  assign req_ready  = state_q == S_IDLE;
  assign accept     = req_ready && req_valid && type_ok && len_ok && !disconnect_sbtx;
  assign req_err    = req_ready && req_valid && !(type_ok && len_ok);
  assign disconnected_s = state_q == S_DISCONNECT;
  assign trans_sent = in_frame && tc && !disconnect_sbtx && (state_q == S_ETX || state_q == S_CLSE);
  // the byte being held on trans decides whether a stuff symbol follows it
  assign stuff      = trans_q[8:1] == DLE && (state_q inside {S_ADDR, S_LEN, S_DATA, S_CRC_H, S_CRC_L});
  assign crc_en     = in_frame && tc && (state_d inside {S_STX, S_ADDR, S_LEN, S_DATA});
  assign data_byte  = 8'(data_q >> {idx_d, 3'b000});
  assign trans       = trans_q;
  assign trans_state = ts_q;
  always_comb begin
    case (state_q)
      S_DLE1:  seq = type_q == RT_LT_LSE ? S_LSE : S_STX;
      S_LSE:   seq = S_CLSE;
      S_STX:   seq = S_ADDR;
      S_ADDR:  seq = S_LEN;
      S_LEN:   seq = has_data ? S_DATA : S_CRC_H;
      S_DATA:  seq = idx_q == len_q - 7'd1 ? S_CRC_H : S_DATA;
      S_CRC_H: seq = S_CRC_L;
      S_CRC_L: seq = S_DLE2;
      S_DLE2:  seq = S_ETX;
      S_STUFF: seq = ret_q;
      default: seq = S_IDLE;
    endcase
  end
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    idx_d   = idx_q;
    if (disconnect_sbtx) state_d = S_DISCONNECT;
    else if (state_q == S_DISCONNECT) state_d = tdisconnect_tx_min ? S_IDLE : S_DISCONNECT;
    else if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_DLE1;
        idx_d   = '0;
      end
    end else if (tc) begin
      state_d = stuff ? S_STUFF : seq;
      ret_d   = seq;
      if (state_q == S_DATA) idx_d = idx_q + 7'd1;
    end
    cnt_d = in_frame && !tc && !disconnect_sbtx ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    case (state_d)
      S_STX:   byte_d = type_q == RT_AT_RD_CMD || type_q == RT_AT_WR_CMD ? STX_CMD : STX_RSP;
      S_LSE:   byte_d = LSE;
      S_CLSE:  byte_d = CLSE;
      S_ADDR:  byte_d = addr_q;
      S_LEN:   byte_d = {wr, len_q};
      S_DATA:  byte_d = data_byte;
      S_CRC_H: byte_d = crc[15:8];
      S_CRC_L: byte_d = crc[7:0];
      S_ETX:   byte_d = ETX;
      default: byte_d = DLE;
    endcase
    trans_d = state_d == S_DISCONNECT ? DISC_SYM : state_d == S_IDLE ? IDLE_SYM : sym(byte_d);
    ts_d    = state_d == S_DISCONNECT ? TS_DISC : state_d == S_IDLE ? TS_IDLE : TS_TX;
  end
  always_ff @(posedge sb_clk or negedge rst)
    if (!rst) begin
      state_q <= S_DISCONNECT;
      ret_q   <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      trans_q <= DISC_SYM;
      ts_q    <= TS_DISC;
      type_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      trans_q <= trans_d;
      ts_q    <= ts_d;
      if (accept) begin
        type_q <= req_type;
        addr_q <= req_addr;
        len_q  <= req_len;
        data_q <= req_data;
      end
    end
  sb_crc16 u_crc (
    .sb_clk (sb_clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (crc_en),
    .data_i (byte_d),
    .crc_o  (crc)
  );
endmodule

// File: tb/tb_sb_trans_gen_par.sv
// tb_sb_trans_gen_par: table-driven and random requests checked cycle by cycle
// against a frame model built from byte lists and a bitwise CRC.
module tb_sb_trans_gen_par;
  localparam int ML = 8;
  localparam int SC = 10;
  localparam int DW = 8 * ML;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [2:0]    t;
    logic [7:0]    a;
    logic [6:0]    l;
    logic [DW-1:0] d;
    logic          err;
    int            cyc;
  } vec_t;
  logic sb_clk = 0, rst = 0, req_valid = 0, disconnect_sbtx = 0, tdisconnect_tx_min = 0;
  logic [2:0] req_type = '0;
  logic [7:0] req_addr = '0;
  logic [6:0] req_len = '0;
  logic [DW-1:0] req_data = '0;
  logic req_ready, trans_sent, req_err, disconnected_s;
  logic [9:0] trans;
  logic [1:0] trans_state;
  int n_cmp = 0, n_fail = 0;
  always #5 sb_clk = ~sb_clk;
  sb_trans_gen_par #(.MAX_LEN(ML), .SYM_CYCLES(SC)) dut (
    .sb_clk(sb_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
    .disconnect_sbtx(disconnect_sbtx), .tdisconnect_tx_min(tdisconnect_tx_min),
    .trans(trans), .trans_state(trans_state), .trans_sent(trans_sent),
    .req_err(req_err), .disconnected_s(disconnected_s)
  );
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge sb_clk);
    #1;
  endtask
  function automatic logic [15:0] crc16(input bq_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i])
      for (int j = 7; j >= 0; j--)
        c = (c[15] ^ b[i][j]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    return c;
  endfunction
  function automatic logic model_err(input logic [2:0] t, input logic [6:0] l);
    return t == 0 || t > 5 || ((t == 3 || t == 4) && (l == 0 || l > ML));
  endfunction
  function automatic void model_frame(input logic [2:0] t, input logic [7:0] a, input logic [6:0] l,
                                      input logic [DW-1:0] d, output bq_t f);
    bq_t body;
    logic [15:0] c;
    f = {};
    if (t == 1) begin
      f = {8'hFE, 8'h80, 8'h7F};
      return;
    end
    body.push_back((t == 2 || t == 4) ? 8'h05 : 8'h04);
    body.push_back(a);
    body.push_back({t >= 3'd4, l});
    if (t == 3 || t == 4) for (int i = 0; i < int'(l); i++) body.push_back(d[8*i +: 8]);
    c = crc16(body);
    body.push_back(c[15:8]);
    body.push_back(c[7:0]);
    f.push_back(8'hFE);
    foreach (body[i]) begin
      f.push_back(body[i]);
      if (i > 0 && body[i] == 8'hFE) f.push_back(8'hFE);
    end
    f.push_back(8'hFE);
    f.push_back(8'h40);
  endfunction
  task automatic apply_err(input logic [2:0] t, input logic [6:0] l);
    req_valid = 1; req_type = t; req_len = l;
    #1;
    chk("err_pulse", req_err, 1);
    chk("err_ready", req_ready, 1);
    step();
    req_valid = 0;
    #1;
    chk("err_trans", trans, 10'h3FF);
    chk("err_state", trans_state, 1);
    chk("err_one_cycle", req_err, 0);
  endtask
  // abort_at >= 0 breaks the frame at that cycle with disconnect (or reset when abort_rst)
  task automatic run_frame(input logic [2:0] t, input logic [7:0] a, input logic [6:0] l,
                           input logic [DW-1:0] d, input int abort_at, input logic abort_rst,
                           output int sent);
    bq_t f;
    int cyc;
    model_frame(t, a, l, d, f);
    req_valid = 1; req_type = t; req_addr = a; req_len = l; req_data = d;
    #1;
    chk("acc_ready", req_ready, 1);
    chk("acc_err", req_err, 0);
    step();
    req_valid = 0;
    sent = 0;
    cyc = 0;
    foreach (f[k])
      for (int c = 0; c < SC; c++) begin
        if (cyc == abort_at) begin
          if (abort_rst) rst = 0;
          else disconnect_sbtx = 1;
          #1;
          chk("abort_sent", trans_sent, 0);
          step();
          chk("abort_trans", trans, 10'h000);
          chk("abort_state", trans_state, 0);
          chk("abort_disc", disconnected_s, 1);
          rst = 1; disconnect_sbtx = 0; tdisconnect_tx_min = 0;
          step();
          chk("hold_disc", trans, 10'h000);
          tdisconnect_tx_min = 1;
          step();
          chk("rel_trans", trans, 10'h3FF);
          chk("rel_ready", req_ready, 1);
          return;
        end
        chk("sym", trans, {1'b1, f[k], 1'b0});
        chk("tx_state", trans_state, 2);
        chk("sent", trans_sent, k == f.size() - 1 && c == SC - 1);
        if (trans_sent && sent == 0) sent = cyc + 1;
        cyc++;
        step();
      end
    chk("post_trans", trans, 10'h3FF);
    chk("post_state", trans_state, 1);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t tbl[11];
    bq_t q;
    int sc;
    logic [2:0] t;
    logic [6:0] l;
    logic [7:0] a;
    logic [DW-1:0] d;
    tbl = '{
      '{3'd2, 8'h4E, 7'd2, 64'h0, 1'b0, 80},
      '{3'd4, 8'h10, 7'd3, 64'h03FE01, 1'b0, 0},
      '{3'd1, 8'h00, 7'd0, 64'h0, 1'b0, 30},
      '{3'd3, 8'h00, 7'd0, 64'h0, 1'b1, 0},
      '{3'd3, 8'h00, 7'd9, 64'h0, 1'b1, 0},
      '{3'd0, 8'h00, 7'd1, 64'h0, 1'b1, 0},
      '{3'd7, 8'h00, 7'd1, 64'h0, 1'b1, 0},
      '{3'd5, 8'hFE, 7'd126, 64'h0, 1'b0, 0},
      '{3'd4, 8'hFE, 7'd8, 64'hFEFE_0011_2233_FE44, 1'b0, 0},
      '{3'd3, 8'h7F, 7'd1, 64'hFE, 1'b0, 0},
      '{3'd4, 8'h00, 7'd9, 64'h1, 1'b1, 0}
    };
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_check", crc16(q), 16'hAEE7);
    step();
    chk("rst_trans", trans, 10'h000);
    chk("rst_state", trans_state, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_sent", trans_sent, 0);
    chk("rst_err", req_err, 0);
    chk("rst_disc", disconnected_s, 1);
    rst = 1;
    step();
    chk("no_min_hold", trans, 10'h000);
    tdisconnect_tx_min = 1;
    step();
    chk("idle_trans", trans, 10'h3FF);
    chk("idle_state", trans_state, 1);
    chk("idle_ready", req_ready, 1);
    chk("idle_disc", disconnected_s, 0);
    foreach (tbl[i]) begin
      if (tbl[i].err) apply_err(tbl[i].t, tbl[i].l);
      else begin
        run_frame(tbl[i].t, tbl[i].a, tbl[i].l, tbl[i].d, -1, 1'b0, sc);
        if (tbl[i].cyc != 0) chk("frame_cycles", sc, tbl[i].cyc);
      end
      step();
    end
    run_frame(3'd4, 8'h22, 7'd4, 64'h44332211, 45, 1'b0, sc);
    run_frame(3'd2, 8'h01, 7'd1, 64'h0, 25, 1'b1, sc);
    run_frame(3'd5, 8'h12, 7'd3, 64'h0, -1, 1'b0, sc);
    run_frame(3'd5, 8'h34, 7'd4, 64'h0, -1, 1'b0, sc);
    chk("b2b_second_cycles", sc, 80);
    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom_range(0, 7));
      l = 7'($urandom_range(0, ML + 1));
      a = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      for (int j = 0; j < ML; j++) d[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      if (model_err(t, l)) apply_err(t, l);
      else run_frame(t, a, l, d, -1, 1'b0, sc);
      if ($urandom_range(0, 1) == 1) step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sb_trans_gen_par.md
SB_TRANS_GEN_PAR -- requirements
Module: sb_trans_gen_par

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum AT data bytes per transaction (1..127).
REQ-002 SHALL have parameter SYM_CYCLES, default 10, meaning sb_clk cycles each 10-bit symbol is held on trans (>=2).
REQ-003 SHALL have port sb_clk  in  1  sideband clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  transaction request.
REQ-006 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_type  in  3  1=LT_LSE, 2=AT_RD_CMD, 3=AT_RD_RSP, 4=AT_WR_CMD, 5=AT_WR_RSP; others reserved.
REQ-008 SHALL have port req_addr  in  8  AT address byte.
REQ-009 SHALL have port req_len  in  7  AT length in bytes.
REQ-010 SHALL have port req_data  in  8*MAX_LEN  AT data; byte 0 = bits [7:0], sent first.
REQ-011 SHALL have port disconnect_sbtx  in  1  forces disconnect.
REQ-012 SHALL have port tdisconnect_tx_min  in  1  minimum disconnect time elapsed.
REQ-013 SHALL have port trans  out  10  symbol {1'b1, byte, 1'b0}; idle 10'h3FF; disconnected 10'h000.
REQ-014 SHALL have port trans_state  out  2  0=disconnected, 1=idle, 2=transmitting.
REQ-015 SHALL have port trans_sent  out  1  one-cycle pulse at frame completion.
REQ-016 SHALL have port req_err  out  1  one-cycle pulse on rejected request.
REQ-017 SHALL have port disconnected_s  out  1  high while in DISCONNECT.

Function
REQ-018 SHALL implement states DISCONNECT, IDLE, DLE1, STX, LSE, CLSE, ADDR, LEN, DATA, CRC_H, CRC_L, STUFF, DLE2, ETX.
REQ-019 SHALL leave DISCONNECT for IDLE only when disconnect_sbtx=0 and tdisconnect_tx_min=1; disconnect_sbtx=1 in any state SHALL enter DISCONNECT next cycle, aborting any frame with no trans_sent.
REQ-020 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready SHALL latch all req_* fields, and DLE1 symbol SHALL appear on trans the following cycle.
REQ-021 SHALL reject (req_err pulse, stay IDLE, no symbols) reserved req_type, or req_len outside 1..MAX_LEN for types 3 and 4.
REQ-022 SHALL hold every symbol exactly SYM_CYCLES cycles; advance on symbol counter terminal count only.
REQ-023 LT_LSE frame SHALL be DLE(FE), LSE(80), CLSE(7F); no CRC.
REQ-024 AT frame SHALL be DLE(FE), STX (05 for types 2/4, 04 for 3/5), addr, len byte, data (types 3/4 only, req_len bytes), CRC_H, CRC_L, DLE(FE), ETX(40).
REQ-025 len byte SHALL be {write bit (1 for types 4/5), req_len}; types 2/5 send req_len value but no data.
REQ-026 CRC SHALL be CRC-16 poly 0x8005, init 0xFFFF, MSB-first, over STX through last data byte, excluding stuffed bytes; reset at DLE1.
REQ-027 Any addr, len, data or CRC byte equal to FE SHALL be followed by one STUFF symbol FE; DLE1/DLE2 SHALL never be stuffed.
REQ-028 trans_sent SHALL pulse in the last cycle of the ETX or CLSE symbol; IDLE re-entered next cycle, trans=3FF.
REQ-029 Back-to-back: request presented during trans_sent cycle SHALL be accepted on the first IDLE cycle.
REQ-030 trans, trans_state SHALL be registered outputs.

Reset
REQ-031 On rst=0: state DISCONNECT, trans=000, trans_state=0, req_ready=0, trans_sent=0, req_err=0, disconnected_s=1, counters and CRC cleared.
REQ-032 Reset mid-frame SHALL discard the latched request; no partial symbol after release.

Structure
REQ-033 Package sb_trans_pkg SHALL hold req_type enum, symbol constants (DLE, STX_CMD, STX_RSP, ETX, LSE, CLSE, IDLE_SYM) and trans_state codes.
REQ-034 CRC SHALL be one sub-module sb_crc16 (byte-wide update, clear, enable, 16-bit out).

Verification
REQ-035 AT_RD_CMD addr 4E len 2 -> symbols FE,05,4E,02,CRC_H,CRC_L,FE,40, 80 cycles, trans_sent at cycle 80, CRC matches golden model.
REQ-036 AT_WR_CMD addr 10 len 3 data {01,FE,03} -> FE,05,10,83,01,FE,FE,03,CRC_H,CRC_L,FE,40; CRC excludes stuffed FE.
REQ-037 LT_LSE -> FE,80,7F, 30 cycles, trans_sent at cycle 30, no CRC symbols.
REQ-038 AT_RD_RSP len 0 and len MAX_LEN+1 -> req_err pulse, trans stays 3FF, req_ready stays 1.
REQ-039 disconnect_sbtx=1 during DATA -> trans=000 next cycle, no trans_sent; release with tdisconnect_tx_min=1 -> IDLE, 3FF.
REQ-040 Two AT_WR_RSP requests back-to-back -> second DLE1 starts one cycle after first trans_sent, no idle gap beyond one cycle.
